train_center_cal_tx: RTL and testbench
======================================

// Module: train_center_cal_tx
// PURPOSE
//  Transmitter-side partner of the MBTRAIN centre-calibration handshake (VALTRAINCENTER/DATATRAINCENTER).
//  Issues start/end requests over sideband, waits for partner responses, and runs the local point test in between.
//  Latches the per-lane result. Shares the sideband mux with the RX-side block via the valid/busy priority scheme.
// PARAMETERS
//  TIMEOUT_CYCLES  8000  max cycles spent in a WAIT_* state before TIMEOUT (must be >=2)
//  CNT_W           13    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk                      in   1   clock (single clock domain)
//  rst                      in   1   reset: synchronous, active-high
//  i_en                     in   1   block enable from MBTRAIN sequencer; low returns to IDLE
//  i_decoded_sideband_message in 4 decoded partner message: 0010 start resp, 0100 end resp
//  i_busy_negedge_detected  in   1   sideband serializer finished sending current message
//  i_valid_rx               in   1   RX-side block currently owns the sideband mux
//  i_pt_done                in   1   point test / sweep finished (1-cycle pulse)
//  i_tx_lanes_result        in   16  per-lane pass mask, valid with i_pt_done
//  o_sideband_message       out  4   0001 start req, 0011 end req, 0000 none
//  o_valid_tx               out  1   request to send o_sideband_message
//  o_pt_en                  out  1   enables point test
//  o_eye_width_sweep_en     out  1   always 0 in this block (sweep owned by RX side); kept for port symmetry
//  o_lanes_result           out  16  latched i_tx_lanes_result
//  o_test_ack               out  1   handshake complete; held until i_en low
//  o_timeout                out  1   partner response not received in time; held until i_en low
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, pending flag 0.
//  States: IDLE, SEND_START_REQ, WAIT_START_RESP, RUN_TEST, SEND_END_REQ, WAIT_END_RESP, TEST_FINISHED, TIMEOUT.
//  - IDLE: i_en -> SEND_START_REQ; outputs cleared every cycle in IDLE.
//  - SEND_START_REQ: message=0001 registered on entry; -> WAIT_START_RESP on valid negedge (o_valid_tx 1->0).
//  - WAIT_START_RESP: msg==0010 -> RUN_TEST, o_pt_en<=1 same edge; counter==TIMEOUT_CYCLES-1 -> TIMEOUT.
//  - RUN_TEST: i_pt_done -> SEND_END_REQ; o_pt_en<=0, o_lanes_result<=i_tx_lanes_result, message<=0011.
//  - SEND_END_REQ: -> WAIT_END_RESP on valid negedge.
//  - WAIT_END_RESP: msg==0100 -> TEST_FINISHED, message<=0000, o_test_ack<=1; timeout as above.
//  - TEST_FINISHED / TIMEOUT: hold outputs; ~i_en -> IDLE.
//  - ~i_en in any non-IDLE state -> IDLE next edge (abort); o_pt_en, o_valid_tx cleared.
//  Response and timeout on same cycle: response wins.
//  Timeout counter: clears on entry to each WAIT_* state; increments each cycle there; saturates; no wrap.
//  Valid handshake (identical rule to RX side):
//   - raise_cond = transition into SEND_START_REQ or SEND_END_REQ.
//   - pending flag: set on raise_cond; cleared on i_busy_negedge_detected && !i_valid_rx.
//   - o_valid_tx: cleared on i_busy_negedge_detected (priority); else set when (raise_cond||pending) && !i_valid_rx.
//   - valid negedge = o_valid_tx==0 && registered o_valid_tx==1.
//  Latency: o_valid_tx rises earliest 1 cycle after entering SEND_*; message stable before valid rises and until valid negedge.
//  Messages other than the expected response are ignored in each WAIT_* state.
//  Synchronous reset mid-handshake: next edge IDLE, all outputs 0, pending cleared.
// STRUCTURE
//  Shared package: state encodings; sideband message codes (SB_START_REQ=0001, SB_START_RESP=0010,
//   SB_END_REQ=0011, SB_END_RESP=0100, SB_NONE=0000).
//  Sub-module sb_valid_arbiter: pending flag, o_valid_tx, valid-negedge detect.
//   Reusable by train_center_cal_rx.
//  Kept in top: FSM, timeout counter, result latch.
// TESTING
//  Nominal: i_en=1, busy pulse 4 cycles after valid, resp 0010, i_pt_done with mask 16'hF0F0, resp 0100
//   -> messages 0001 then 0011, o_pt_en high only in RUN_TEST, o_lanes_result=16'hF0F0, o_test_ack=1.
//  Mux contention: i_valid_rx=1 while entering SEND_START_REQ -> o_valid_tx stays 0;
//   o_valid_tx rises 1 cycle after i_valid_rx falls; pending clears.
//  Timeout: TIMEOUT_CYCLES=16, no response -> TIMEOUT state after 16 WAIT cycles, o_timeout=1,
//   o_test_ack=0; i_en low -> IDLE.
//  Response on the final timeout cycle -> RUN_TEST, o_timeout stays 0.
//  Abort: drop i_en during RUN_TEST -> IDLE next edge, o_pt_en=0; re-enable restarts with 0001.
//  rst=1 during WAIT_END_RESP -> all outputs 0 after one edge; stray 0100 in WAIT_START_RESP ignored.

Source files
------------

// File: rtl/train_center_cal_tx_pkg.sv
// Shared types and sideband message codes for the MBTRAIN centre-calibration blocks.
package train_center_cal_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSendStartReq,
        StWaitStartResp,
        StRunTest,
        StSendEndReq,
        StWaitEndResp,
        StTestFinished,
        StTimeout
    } state_t;

    typedef logic [3:0]  sb_msg_t;
    typedef logic [15:0] lanes_t;

    localparam sb_msg_t SB_NONE       = 4'b0000;
    localparam sb_msg_t SB_START_REQ  = 4'b0001;
    localparam sb_msg_t SB_START_RESP = 4'b0010;
    localparam sb_msg_t SB_END_REQ    = 4'b0011;
    localparam sb_msg_t SB_END_RESP   = 4'b0100;

    function automatic logic is_wait(input state_t s);
        return (s == StWaitStartResp) || (s == StWaitEndResp);
    endfunction

    function automatic logic is_send(input state_t s);
        return (s == StSendStartReq) || (s == StSendEndReq);
    endfunction

endpackage

// File: rtl/train_center_cal_tx_if.sv
// Sequencer/sideband/point-test signal bundle of the TX centre-calibration block.
interface train_center_cal_tx_if;
    import train_center_cal_tx_pkg::*;

    logic    i_en;
    sb_msg_t i_decoded_sideband_message;
    logic    i_busy_negedge_detected;
    logic    i_valid_rx;
    logic    i_pt_done;
    lanes_t  i_tx_lanes_result;
    sb_msg_t o_sideband_message;
    logic    o_valid_tx;
    logic    o_pt_en;
    logic    o_eye_width_sweep_en;
    lanes_t  o_lanes_result;
    logic    o_test_ack;
    logic    o_timeout;

    // The calibration block itself.
    modport master (
        input  i_en, i_decoded_sideband_message, i_busy_negedge_detected, i_valid_rx,
        input  i_pt_done, i_tx_lanes_result,
        output o_sideband_message, o_valid_tx, o_pt_en, o_eye_width_sweep_en,
        output o_lanes_result, o_test_ack, o_timeout
    );

    // The surrounding sequencer / sideband / point-test logic.
    modport slave (
        output i_en, i_decoded_sideband_message, i_busy_negedge_detected, i_valid_rx,
        output i_pt_done, i_tx_lanes_result,
        input  o_sideband_message, o_valid_tx, o_pt_en, o_eye_width_sweep_en,
        input  o_lanes_result, o_test_ack, o_timeout
    );

endinterface

// File: rtl/train_center_cal_tx_sb_valid_arbiter.sv
// Sideband valid generator shared by the TX/RX calibration blocks: holds a request
// pending while the other block owns the mux, drops valid when the serializer is done.
module sb_valid_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic raise_i,
    input  logic busy_negedge_i,
    input  logic valid_rx_i,
    output logic valid_o,
    output logic valid_negedge_o
);

    logic pending_q, pending_d;
    logic valid_q, valid_d;
    logic valid_prev_q;

    // Next pending/valid; serializer completion has priority over a new raise of valid.
    always_comb begin
        pending_d = pending_q;
        valid_d   = valid_q;
        if (raise_i) begin
            pending_d = 1'b1;
        end else if (busy_negedge_i && !valid_rx_i) begin
            pending_d = 1'b0;
        end
        if (busy_negedge_i) begin
            valid_d = 1'b0;
        end else if ((raise_i || pending_q) && !valid_rx_i) begin
            valid_d = 1'b1;
        end
    end

    // State registers; clr_i aborts any handshake in flight.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            pending_q    <= 1'b0;
            valid_q      <= 1'b0;
            valid_prev_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            valid_q      <= valid_d;
            valid_prev_q <= valid_q;
        end
    end

    assign valid_o         = valid_q;
    assign valid_negedge_o = !valid_q && valid_prev_q;

endmodule

// File: rtl/train_center_cal_tx.sv
// TX side of the MBTRAIN centre-calibration handshake: start req/resp, local point
// test, end req/resp, with a per-wait timeout and a latched per-lane result.
module train_center_cal_tx
    import train_center_cal_tx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 8000,
    parameter int unsigned CNT_W          = 13
) (
    input logic              clk,
    input logic              rst,
    train_center_cal_tx_if.master bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sb_msg_t          msg_q, msg_d;
    lanes_t           lanes_q, lanes_d;
    logic             pt_en_q, pt_en_d;
    logic             ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic             raise_q, raise_d;
    logic             valid_tx;
    logic             valid_negedge;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CntMax);

    // Next state and registered outputs.
    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        lanes_d   = lanes_q;
        pt_en_d   = pt_en_q;
        ack_d     = ack_q;
        timeout_d = timeout_q;
        if (!bus.i_en || state_q == StIdle) begin
            state_d   = StIdle;
            msg_d     = SB_NONE;
            lanes_d   = '0;
            pt_en_d   = 1'b0;
            ack_d     = 1'b0;
            timeout_d = 1'b0;
            if (bus.i_en) begin
                state_d = StSendStartReq;
                msg_d   = SB_START_REQ;
            end
        end else begin
            unique case (state_q)
                StSendStartReq: if (valid_negedge) state_d = StWaitStartResp;
                StWaitStartResp: begin
                    // A response on the last counted cycle still wins.
                    if (bus.i_decoded_sideband_message == SB_START_RESP) begin
                        state_d = StRunTest;
                        pt_en_d = 1'b1;
                    end else if (timeout_hit) begin
                        state_d   = StTimeout;
                        timeout_d = 1'b1;
                    end
                end
                StRunTest: begin
                    if (bus.i_pt_done) begin
                        state_d = StSendEndReq;
                        pt_en_d = 1'b0;
                        lanes_d = bus.i_tx_lanes_result;
                        msg_d   = SB_END_REQ;
                    end
                end
                StSendEndReq: if (valid_negedge) state_d = StWaitEndResp;
                StWaitEndResp: begin
                    if (bus.i_decoded_sideband_message == SB_END_RESP) begin
                        state_d = StTestFinished;
                        msg_d   = SB_NONE;
                        ack_d   = 1'b1;
                    end else if (timeout_hit) begin
                        state_d   = StTimeout;
                        timeout_d = 1'b1;
                    end
                end
                StTestFinished, StTimeout: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Wait counter restarts on entry to a WAIT state; raise pulses one cycle after
    // entering a SEND state so the message is already stable when valid rises.
    always_comb begin
        cnt_d = '0;
        if (is_wait(state_q) && state_d == state_q) begin
            cnt_d = timeout_hit ? cnt_q : cnt_q + CNT_W'(1);
        end
        raise_d = is_send(state_d) && (state_d != state_q);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            msg_q     <= SB_NONE;
            lanes_q   <= '0;
            pt_en_q   <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            raise_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            msg_q     <= msg_d;
            lanes_q   <= lanes_d;
            pt_en_q   <= pt_en_d;
            ack_q     <= ack_d;
            timeout_q <= timeout_d;
            raise_q   <= raise_d;
        end
    end

    sb_valid_arbiter u_arb (
        .clk            (clk),
        .rst            (rst),
        .clr_i          (!bus.i_en),
        .raise_i        (raise_q),
        .busy_negedge_i (bus.i_busy_negedge_detected),
        .valid_rx_i     (bus.i_valid_rx),
        .valid_o        (valid_tx),
        .valid_negedge_o(valid_negedge)
    );

    assign bus.o_sideband_message   = msg_q;
    assign bus.o_valid_tx           = valid_tx;
    assign bus.o_pt_en              = pt_en_q;
    assign bus.o_eye_width_sweep_en = 1'b0;
    assign bus.o_lanes_result       = lanes_q;
    assign bus.o_test_ack           = ack_q;
    assign bus.o_timeout            = timeout_q;

endmodule

// File: tb/tb_train_center_cal_tx.sv
// Randomized scoreboard bench for train_center_cal_tx with a behavioural partner.
module tb_train_center_cal_tx;
    import train_center_cal_tx_pkg::*;

    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    train_center_cal_tx_if bus ();

    train_center_cal_tx #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_q[$];
    int unsigned ser_lat = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Partner serializer: pulses busy-negedge ser_lat cycles after valid rises.
    initial begin
        logic prev;
        prev = 1'b0;
        bus.i_busy_negedge_detected = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_valid_tx && !prev) begin
                for (int k = 1; k < int'(ser_lat); k++) begin
                    @(posedge clk);
                    #1;
                end
                bus.i_busy_negedge_detected = 1'b1;
                @(posedge clk);
                #1;
                bus.i_busy_negedge_detected = 1'b0;
            end
            prev = bus.o_valid_tx;
        end
    end

    // Monitor: every valid rise must carry the next expected request, held while valid.
    initial begin
        logic       mprev;
        logic [3:0] cur;
        mprev = 1'b0;
        cur   = '0;
        forever begin
            @(negedge clk);
            if (bus.o_valid_tx && !mprev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got msg %0h expected no request",
                             bus.o_sideband_message);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("sb_msg", bus.o_sideband_message, e);
                end
                cur = bus.o_sideband_message;
            end else if (bus.o_valid_tx) begin
                check("msg_stable", bus.o_sideband_message, cur);
            end
            mprev = bus.o_valid_tx;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Wait for one valid high/low cycle, then one more edge so the FSM sits in WAIT.
    task automatic wait_handshake(input string name);
        int n;
        n = 0;
        while (!bus.o_valid_tx && n < 100) begin tick(); n++; end
        while (bus.o_valid_tx && n < 100) begin tick(); n++; end
        check({name, "_handshake"}, n < 100, 1);
        tick();
    endtask

    task automatic respond(input logic [3:0] m);
        bus.i_decoded_sideband_message = m;
        tick();
        bus.i_decoded_sideband_message = SB_NONE;
    endtask

    task automatic finish_test(input logic [15:0] mask);
        bus.i_pt_done         = 1'b1;
        bus.i_tx_lanes_result = mask;
        exp_q.push_back(SB_END_REQ);
        tick();
        bus.i_pt_done         = 1'b0;
        bus.i_tx_lanes_result = 16'($urandom);
        check("pt_en_off", bus.o_pt_en, 0);
        check("lanes", bus.o_lanes_result, mask);
    endtask

    task automatic run_txn(input logic [15:0] mask, input int d1, input int d2,
                           input int d3, input bit stray);
        exp_q.push_back(SB_START_REQ);
        bus.i_en = 1'b1;
        wait_handshake("start");
        if (stray) respond(SB_END_RESP);
        tick(d1);
        check("pt_en_before_resp", bus.o_pt_en, 0);
        respond(SB_START_RESP);
        check("pt_en_run", bus.o_pt_en, 1);
        check("sweep_en", bus.o_eye_width_sweep_en, 0);
        tick(d2);
        finish_test(mask);
        wait_handshake("end");
        if (stray) respond(SB_START_RESP);
        tick(d3);
        check("ack_before_resp", bus.o_test_ack, 0);
        respond(SB_END_RESP);
        check("ack", bus.o_test_ack, 1);
        check("msg_none", bus.o_sideband_message, SB_NONE);
        check("no_timeout", bus.o_timeout, 0);
        tick(2);
        check("ack_hold", {bus.o_test_ack, bus.o_lanes_result}, {1'b1, mask});
        bus.i_en = 1'b0;
        tick();
        check("ack_clear", {bus.o_test_ack, bus.o_lanes_result}, 0);
        tick(2);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_en = 1'b0;
        bus.i_decoded_sideband_message = SB_NONE;
        bus.i_valid_rx = 1'b0;
        bus.i_pt_done = 1'b0;
        bus.i_tx_lanes_result = '0;
        tick(3);
        check("reset_outputs", {bus.o_sideband_message, bus.o_valid_tx, bus.o_pt_en,
              bus.o_eye_width_sweep_en, bus.o_lanes_result, bus.o_test_ack, bus.o_timeout}, 0);
        rst = 1'b0;
        tick(2);

        // Nominal then randomized transactions.
        run_txn(16'hF0F0, 2, 3, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ser_lat = $urandom_range(1, 6);
            run_txn(16'($urandom), $urandom_range(0, 8), $urandom_range(0, 5),
                    $urandom_range(0, 8), 1'($urandom_range(0, 1)));
        end
        ser_lat = 4;

        // Mux contention: valid held off until the RX side releases the mux.
        bus.i_valid_rx = 1'b1;
        exp_q.push_back(SB_START_REQ);
        bus.i_en = 1'b1;
        tick(6);
        check("contention_hold", bus.o_valid_tx, 0);
        bus.i_valid_rx = 1'b0;
        tick();
        check("contention_rise", bus.o_valid_tx, 1);
        wait_handshake("contention");
        tick(5);
        check("pending_cleared", bus.o_valid_tx, 0);
        bus.i_en = 1'b0;
        tick(3);

        // Timeout with no partner response.
        exp_q.push_back(SB_START_REQ);
        bus.i_en = 1'b1;
        wait_handshake("to_start");
        tick(TO - 1);
        check("timeout_early", bus.o_timeout, 0);
        tick();
        check("timeout_set", {bus.o_timeout, bus.o_test_ack, bus.o_pt_en}, 3'b100);
        tick(3);
        check("timeout_hold", bus.o_timeout, 1);
        bus.i_en = 1'b0;
        tick();
        check("timeout_clear", bus.o_timeout, 0);
        tick(2);

        // Response on the final timeout cycle, then abort during RUN_TEST and restart.
        exp_q.push_back(SB_START_REQ);
        bus.i_en = 1'b1;
        wait_handshake("last_cycle");
        tick(TO - 1);
        respond(SB_START_RESP);
        check("last_cycle_run", {bus.o_pt_en, bus.o_timeout}, 2'b10);
        tick(3);
        bus.i_en = 1'b0;
        tick();
        check("abort_pt_en", {bus.o_pt_en, bus.o_valid_tx}, 0);
        tick(2);
        exp_q.push_back(SB_START_REQ);
        bus.i_en = 1'b1;
        wait_handshake("restart");
        bus.i_en = 1'b0;
        tick(3);

        // Stray end response ignored, then reset during WAIT_END_RESP.
        exp_q.push_back(SB_START_REQ);
        bus.i_en = 1'b1;
        wait_handshake("rst_start");
        respond(SB_END_RESP);
        tick();
        check("stray_ignored", {bus.o_pt_en, bus.o_timeout, bus.o_test_ack}, 0);
        respond(SB_START_RESP);
        finish_test(16'hA5C3);
        wait_handshake("rst_end");
        check("pre_reset_lanes", bus.o_lanes_result, 16'hA5C3);
        rst = 1'b1;
        tick();
        check("mid_reset_outputs", {bus.o_sideband_message, bus.o_valid_tx, bus.o_pt_en,
              bus.o_eye_width_sweep_en, bus.o_lanes_result, bus.o_test_ack, bus.o_timeout}, 0);
        bus.i_en = 1'b0;
        tick();
        rst = 1'b0;
        tick(5);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
